tc_ps_acp_wr_sched: RTL and testbench

- Round-robin write scheduler that shares the single ACP write-burst engine (tx_en/tx_rdy/tx_awaddr/tx_awid/tx_wdata/tx_wdreq interface) between N streaming requesters.
- Each requester owns a ring buffer in PS memory, defined by a base address and a length in bursts.
- The scheduler generates burst addresses, issues one fixed-length burst per grant, steers per-beat data requests to the granted requester and muxes its data back.
- Sits between the PL data producers and the ACP top-level wrapper.

---
 rtl/tc_ps_acp_pkg.sv | 18 +
 rtl/tc_ps_acp_rr_arb.sv | 31 +++
 rtl/tc_ps_acp_wr_sched.sv | 178 +++++++++++++++++
 tb/tb_tc_ps_acp_wr_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_ps_acp_pkg.sv
// Shared constants and types for the ACP write scheduler.
// Burst sizing, channel-index width and the scheduler state encoding.
package tc_ps_acp_pkg;

    localparam int unsigned BEAT_BYTES  = 8;
    localparam int unsigned DEF_BEATS   = 16;
    localparam int unsigned BURST_BYTES = DEF_BEATS * BEAT_BYTES;
    localparam int unsigned CH_IDX_W    = 3;
    localparam int unsigned CH_MAX      = 1 << CH_IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA,
        DRAIN
    } state_e;

endpackage

// File: rtl/tc_ps_acp_rr_arb.sv
// Combinational round-robin pick: first valid channel strictly after rr_ptr_i,
// wrapping modulo N_CH.
module tc_ps_acp_rr_arb
    import tc_ps_acp_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]     req_valid_i,
    input  logic [CH_IDX_W-1:0] rr_ptr_i,
    output logic [CH_IDX_W-1:0] winner_o,
    output logic                any_o
);

    logic [CH_MAX-1:0]   vld_pad;
    logic [CH_IDX_W-1:0] cand;

    always_comb begin
        vld_pad  = CH_MAX'(req_valid_i);
        any_o    = |req_valid_i;
        winner_o = '0;
        cand     = '0;
        // Walk from farthest to nearest so the nearest valid channel wins.
        for (int unsigned k = N_CH; k >= 1; k--) begin
            cand = CH_IDX_W'((32'(rr_ptr_i) + k) % N_CH);
            if (vld_pad[cand]) begin
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/tc_ps_acp_wr_sched.sv
// Round-robin scheduler sharing one ACP write-burst engine between N_CH ring-buffer
// producers: one fixed-length burst per grant, beat requests steered to the granted channel.
module tc_ps_acp_wr_sched
    import tc_ps_acp_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic [N_CH*32-1:0]   cfg_base,
    input  logic [N_CH*16-1:0]   cfg_bursts,
    input  logic [N_CH-1:0]      req_valid,
    output logic [N_CH-1:0]      req_grant,
    output logic [N_CH-1:0]      req_wdreq,
    input  logic [N_CH*64-1:0]   req_wdata,
    output logic [N_CH*16-1:0]   req_idx,
    output logic                 tx_en,
    input  logic                 tx_rdy,
    output logic [31:0]          tx_awaddr,
    output logic [2:0]           tx_awid,
    output logic [63:0]          tx_wdata,
    input  logic                 tx_wdreq,
    output logic                 busy,
    output logic                 err_wdreq
);

    localparam int unsigned BurstBytes = BEATS * BEAT_BYTES;
    localparam int unsigned BeatW      = $clog2(BEATS + 1);

    state_e              state_q, state_d;
    logic [CH_IDX_W-1:0] rr_q, rr_d;
    logic [CH_IDX_W-1:0] gnt_q, gnt_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic                drain_first_q, drain_first_d;
    logic [15:0]         bursts_q, bursts_d;
    logic [31:0]         awaddr_q, awaddr_d;
    logic                tx_en_q, tx_en_d;
    logic [N_CH-1:0]     grant_q, grant_d;
    logic                err_q, err_d;
    logic [15:0]         idx_q [CH_MAX];
    logic [15:0]         idx_d [CH_MAX];

    logic [31:0]         base_pad   [CH_MAX];
    logic [15:0]         bursts_pad [CH_MAX];
    logic [63:0]         wdata_pad  [CH_MAX];
    logic [CH_IDX_W-1:0] win;
    logic                any_vld;
    logic [15:0]         idx_nxt;

    tc_ps_acp_rr_arb #(
        .N_CH (N_CH)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_q),
        .winner_o    (win),
        .any_o       (any_vld)
    );

    // Unused upper slots read as zero so a 3-bit channel index can address them safely.
    always_comb begin
        for (int i = 0; i < CH_MAX; i++) begin
            base_pad[i]   = '0;
            bursts_pad[i] = '0;
            wdata_pad[i]  = '0;
        end
        for (int i = 0; i < N_CH; i++) begin
            base_pad[i]   = cfg_base[32*i +: 32];
            bursts_pad[i] = cfg_bursts[16*i +: 16];
            wdata_pad[i]  = req_wdata[64*i +: 64];
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        gnt_d         = gnt_q;
        beat_d        = beat_q;
        drain_first_d = drain_first_q;
        bursts_d      = bursts_q;
        awaddr_d      = awaddr_q;
        idx_d         = idx_q;
        tx_en_d       = 1'b0;
        grant_d       = '0;
        idx_nxt       = '0;
        err_d         = err_q | (tx_wdreq && (state_q != DATA));

        case (state_q)
            IDLE: begin
                if (cfg_en && any_vld && tx_rdy) begin
                    state_d  = ISSUE;
                    gnt_d    = win;
                    rr_d     = win;
                    bursts_d = bursts_pad[win];
                    awaddr_d = base_pad[win] + (32'(idx_pad_sel(win)) * 32'(BurstBytes));
                    tx_en_d  = 1'b1;
                    grant_d  = N_CH'(1) << win;
                end
            end
            ISSUE: begin
                // 16-bit wrap makes a ring length of 0 behave as 65536.
                idx_nxt       = idx_q[gnt_q] + 16'd1;
                idx_d[gnt_q]  = (idx_nxt == bursts_q) ? 16'd0 : idx_nxt;
                beat_d        = '0;
                state_d       = DATA;
            end
            DATA: begin
                if (tx_wdreq) begin
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatW'(BEATS - 1)) begin
                        state_d       = DRAIN;
                        drain_first_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                drain_first_d = 1'b0;
                if (!drain_first_q && tx_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    function automatic logic [15:0] idx_pad_sel(input logic [CH_IDX_W-1:0] ch);
        return idx_q[ch];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_q          <= CH_IDX_W'(N_CH - 1);
            gnt_q         <= '0;
            beat_q        <= '0;
            drain_first_q <= 1'b0;
            bursts_q      <= '0;
            awaddr_q      <= '0;
            tx_en_q       <= 1'b0;
            grant_q       <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < CH_MAX; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            gnt_q         <= gnt_d;
            beat_q        <= beat_d;
            drain_first_q <= drain_first_d;
            bursts_q      <= bursts_d;
            awaddr_q      <= awaddr_d;
            tx_en_q       <= tx_en_d;
            grant_q       <= grant_d;
            err_q         <= err_d;
            idx_q         <= idx_d;
        end
    end

    always_comb begin
        req_wdreq = '0;
        req_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_wdreq[i]        = (state_q == DATA) && tx_wdreq && (gnt_q == CH_IDX_W'(i));
            req_idx[16*i +: 16] = idx_q[i];
        end
    end

    assign tx_wdata  = (state_q == IDLE) ? 64'd0 : wdata_pad[gnt_q];
    assign tx_en     = tx_en_q;
    assign req_grant = grant_q;
    assign tx_awaddr = awaddr_q;
    assign tx_awid   = gnt_q;
    assign busy      = (state_q != IDLE);
    assign err_wdreq = err_q;

endmodule

// File: tb/tb_tc_ps_acp_wr_sched.sv
// Directed bench for the ACP write scheduler: addresses, round-robin order, beat routing,
// enable drop, stray beat requests and mid-burst reset.
module tb_tc_ps_acp_wr_sched;

    localparam int N_CH  = 4;
    localparam int BEATS = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_en;
    logic [N_CH*32-1:0]   cfg_base;
    logic [N_CH*16-1:0]   cfg_bursts;
    logic [N_CH-1:0]      req_valid;
    logic [N_CH-1:0]      req_grant;
    logic [N_CH-1:0]      req_wdreq;
    logic [N_CH*64-1:0]   req_wdata;
    logic [N_CH*16-1:0]   req_idx;
    logic                 tx_en;
    logic                 tx_rdy;
    logic [31:0]          tx_awaddr;
    logic [2:0]           tx_awid;
    logic [63:0]          tx_wdata;
    logic                 tx_wdreq;
    logic                 busy;
    logic                 err_wdreq;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    longint last_en = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tc_ps_acp_wr_sched #(
        .N_CH  (N_CH),
        .BEATS (BEATS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_base   (cfg_base),
        .cfg_bursts (cfg_bursts),
        .req_valid  (req_valid),
        .req_grant  (req_grant),
        .req_wdreq  (req_wdreq),
        .req_wdata  (req_wdata),
        .req_idx    (req_idx),
        .tx_en      (tx_en),
        .tx_rdy     (tx_rdy),
        .tx_awaddr  (tx_awaddr),
        .tx_awid    (tx_awid),
        .tx_wdata   (tx_wdata),
        .tx_wdreq   (tx_wdreq),
        .busy       (busy),
        .err_wdreq  (err_wdreq)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int ch, input int b);
        return {8'(8'hA0 + ch), 24'h0, 32'(b)};
    endfunction

    task automatic set_data(input int b);
        for (int c = 0; c < N_CH; c++) req_wdata[64*c +: 64] = pat(c, b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_en = -1;
    endtask

    task automatic wait_en(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tx_en_timeout", 0, 1);
    endtask

    // One grant plus nbeats beat requests; stop_at drops cfg_en at that beat (-1: never).
    task automatic burst(input int ch, input logic [31:0] addr, input logic [15:0] idx_after,
                         input int nbeats, input int stop_at);
        logic ok;
        wait_en(ok);
        if (!ok) return;
        if (last_en >= 0) chk("spacing", 64'((cyc - last_en) >= BEATS + 3), 1);
        last_en = cyc;
        chk("grant", 64'(req_grant), 64'(1 << ch));
        chk("awaddr", 64'(tx_awaddr), 64'(addr));
        chk("awid", 64'(tx_awid), 64'(ch));
        chk("busy_issue", 64'(busy), 1);
        tick();
        chk("en_single_pulse", 64'({tx_en, req_grant}), 0);
        chk("req_idx", 64'(req_idx[16*ch +: 16]), 64'(idx_after));
        for (int b = 0; b < nbeats; b++) begin
            if (b == stop_at) cfg_en = 1'b0;
            set_data(b);
            tx_wdreq = 1'b1;
            @(negedge clk);
            chk("wdreq_route", 64'(req_wdreq), 64'(1 << ch));
            chk("wdata", tx_wdata, pat(ch, b));
            tick();
        end
        tx_wdreq = 1'b0;
    endtask

    initial begin
        int cnt;
        rst        = 1'b1;
        cfg_en     = 1'b0;
        cfg_base   = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        cfg_bursts = {16'd0, 16'd0, 16'd0, 16'd2};
        req_valid  = '0;
        req_wdata  = '0;
        tx_rdy     = 1'b1;
        tx_wdreq   = 1'b0;
        do_reset();

        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_tx_en", 64'(tx_en), 0);
        chk("rst_awaddr", 64'(tx_awaddr), 0);
        chk("rst_awid", 64'(tx_awid), 0);
        chk("rst_req_idx", 64'(req_idx), 0);
        chk("rst_grant", 64'({req_grant, req_wdreq}), 0);
        chk("rst_err", 64'(err_wdreq), 0);

        // Channel 0 alone on a two-burst ring.
        cfg_en    = 1'b1;
        req_valid = 4'b0001;
        burst(0, 32'h1000_0000, 16'd1, BEATS, -1);
        burst(0, 32'h1000_0080, 16'd0, BEATS, -1);
        burst(0, 32'h1000_0000, 16'd1, BEATS, -1);
        req_valid = '0;

        // All channels requesting: strict rotation from channel 0.
        do_reset();
        req_valid = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                logic [31:0] a;
                a = cfg_base[32*c +: 32] + 32'(r * 128);
                burst(c, a, (c == 0) ? 16'(1 - r) : 16'(r + 1), BEATS, -1);
            end
        end

        // Enable dropped mid-burst: burst completes, nothing further granted.
        burst(0, 32'h1000_0000, 16'd1, BEATS, 5);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_en) cnt++;
        end
        chk("no_grant_disabled", 64'(cnt), 0);
        chk("idle_disabled", 64'(busy), 0);

        // Stray beat request while idle.
        tick();
        tx_wdreq = 1'b1;
        @(negedge clk);
        chk("idle_wdreq_unrouted", 64'(req_wdreq), 0);
        tick();
        tx_wdreq = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err_wdreq), 1);
        chk("idle_still", 64'(busy), 0);
        tick();
        cfg_en = 1'b1;
        burst(1, 32'h2000_0100, 16'd3, BEATS, -1);
        req_valid = '0;
        tx_wdreq  = 1'b1;
        @(negedge clk);
        chk("drain_wdreq_unrouted", 64'(req_wdreq), 0);
        tick();
        tx_wdreq = 1'b0;
        @(negedge clk);
        chk("err_sticky", 64'(err_wdreq), 1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("err_cleared", 64'(err_wdreq), 0);
        rst = 1'b0;
        last_en = -1;
        tick();

        // Reset in the middle of a channel-2 burst.
        req_valid = 4'b0100;
        burst(2, 32'h3000_0000, 16'd1, 8, -1);
        rst      = 1'b1;
        tx_wdreq = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_req_idx", 64'(req_idx), 0);
        chk("midrst_tx_en", 64'(tx_en), 0);
        chk("midrst_wdreq", 64'(req_wdreq), 0);
        tx_wdreq = 1'b0;
        tick();
        rst     = 1'b0;
        last_en = -1;
        burst(2, 32'h3000_0000, 16'd1, BEATS, -1);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
